// File: rtl/iomem_ctrl.sv
// iomem_ctrl: slave-side transaction controller for the PicoSoC iomem bus.
// One outstanding request is decoded to GPIO, SimpleRNG or user RAM, the
// target access is sequenced (RNG wait states, fixed RAM read latency) and a
// single-cycle iomem_ready is returned.
// Optional build macro IOMEM_STATS_EN adds a read-only status word at
// 0x0300_3000 (completed transactions / RNG timeouts).
module iomem_ctrl #(
  parameter int          RAM_ADDR_BIT   = 8,
  parameter int          RAM_LAT        = 1,
  parameter int          RNG_TIMEOUT    = 64,
  parameter logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    iomem_valid,
  output logic                    iomem_ready,
  input  logic [3:0]              iomem_wstrb,
  input  logic [31:0]             iomem_addr,
  input  logic [31:0]             iomem_wdata,
  output logic [31:0]             iomem_rdata,
  output logic [31:0]             gpio_o,
  output logic                    rng_we,
  output logic                    rng_re,
  output logic [31:0]             rng_di,
  input  logic [31:0]             rng_do,
  input  logic                    rng_wait,
  output logic [3:0]              ram_we,
  output logic                    ram_re,
  output logic [RAM_ADDR_BIT-1:0] ram_addr,
  output logic [31:0]             ram_di,
  input  logic [31:0]             ram_do,
  output logic                    timeout_o
);

  // counter is shared between the RNG wait budget and the RAM latency count
  localparam int CW = ($clog2(RNG_TIMEOUT + 1) > 3) ? $clog2(RNG_TIMEOUT + 1) : 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_RNG_WAIT,
    S_RAM_RD,
    S_RESP
  } state_t;

  typedef enum logic [2:0] {
    T_NONE,
    T_GPIO,
    T_RNG,
    T_RAM,
    T_STAT
  } tgt_t;

  state_t                  state_q;
  tgt_t                    tgt_q;
  tgt_t                    tgt_dec;
  logic [3:0]              wstrb_q;
  logic [31:0]             wdata_q;
  logic [RAM_ADDR_BIT-1:0] raddr_q;
  logic [CW-1:0]           cnt_q;
  logic                    abort_q;
  logic                    ready_q;
  logic [31:0]             rdata_q;
  logic [31:0]             gpio_q;
  logic                    timeout_q;

  logic                    wr;
  logic                    keep;
  logic                    fin;
  logic [31:0]             fin_rdata;
  logic                    to_hit;
  logic                    acc;
  logic                    rng_go;
  state_t                  done_state;

`ifdef IOMEM_STATS_EN
  logic [15:0]             txcnt_q;
  logic [7:0]              tocnt_q;
`endif

  assign wr         = |wstrb_q;
  // a request withdrawn before completion still finishes its target access
  // but must not see a ready pulse
  assign keep       = iomem_valid && !abort_q;
  assign done_state = keep ? S_RESP : S_IDLE;
  assign acc        = (state_q == S_ACCESS);

  // address decode of the incoming request
  always_comb begin
    tgt_dec = T_NONE;
    if (iomem_addr == 32'h0300_0000)
      tgt_dec = T_GPIO;
    else if (iomem_addr == 32'h0300_1000)
      tgt_dec = T_RNG;
    else if ((iomem_addr[31:12] == 20'h03002) &&
             ((iomem_addr[11:0] >> RAM_ADDR_BIT) == 12'd0))
      tgt_dec = T_RAM;
`ifdef IOMEM_STATS_EN
    else if (iomem_addr == 32'h0300_3000)
      tgt_dec = T_STAT;
`endif
  end

  // completion condition and the read data to return for this cycle
  always_comb begin
    fin       = 1'b0;
    fin_rdata = 32'h0;
    to_hit    = 1'b0;
    case (state_q)
      S_ACCESS: begin
        case (tgt_q)
          T_GPIO: begin
            fin       = 1'b1;
            fin_rdata = gpio_q;
          end
          T_RNG: begin
            if (!rng_wait) begin
              fin       = 1'b1;
              fin_rdata = wr ? 32'h0 : rng_do;
            end
          end
          T_RAM: begin
            if (wr) fin = 1'b1;
          end
`ifdef IOMEM_STATS_EN
          T_STAT: begin
            fin       = 1'b1;
            fin_rdata = {8'h00, tocnt_q, txcnt_q};
          end
`endif
          default: begin
            fin       = 1'b1;
            fin_rdata = UNMAPPED_RDATA;
          end
        endcase
      end
      S_RNG_WAIT: begin
        if (keep && rng_wait && (cnt_q == CW'(RNG_TIMEOUT - 1))) begin
          fin       = 1'b1;
          to_hit    = 1'b1;
          fin_rdata = 32'hFFFF_FFFF;
        end
      end
      S_RAM_RD: begin
        if (cnt_q == CW'(RAM_LAT)) begin
          fin       = 1'b1;
          fin_rdata = ram_do;
        end
      end
      default: ;
    endcase
  end

  // transaction FSM with registered bus-side outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      tgt_q     <= T_NONE;
      wstrb_q   <= 4'h0;
      wdata_q   <= 32'h0;
      raddr_q   <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= 32'h0;
      gpio_q    <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q != S_IDLE) && !iomem_valid) abort_q <= 1'b1;
      if (fin) begin
        state_q <= done_state;
        ready_q <= keep;
        if (keep) rdata_q <= fin_rdata;
      end
      case (state_q)
        S_IDLE: begin
          if (iomem_valid && !ready_q) begin
            tgt_q   <= tgt_dec;
            wstrb_q <= iomem_wstrb;
            wdata_q <= iomem_wdata;
            raddr_q <= iomem_addr[RAM_ADDR_BIT-1:0];
            cnt_q   <= '0;
            abort_q <= 1'b0;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (tgt_q == T_GPIO) begin
            for (int b = 0; b < 4; b++)
              if (wstrb_q[b]) gpio_q[8*b +: 8] <= wdata_q[8*b +: 8];
            if (wstrb_q[3] && wdata_q[31]) timeout_q <= 1'b0;
          end
          if (!fin) begin
            if (tgt_q == T_RNG) begin
              state_q <= S_RNG_WAIT;
            end else begin
              state_q <= S_RAM_RD;
              cnt_q   <= CW'(1);
            end
          end
        end
        S_RNG_WAIT: begin
          if (!keep)
            state_q <= S_IDLE;
          else if (!rng_wait)
            state_q <= S_ACCESS;
          else if (to_hit)
            timeout_q <= 1'b1;
          else
            cnt_q <= cnt_q + CW'(1);
        end
        S_RAM_RD: begin
          if (!fin) cnt_q <= cnt_q + CW'(1);
        end
        S_RESP: begin
          ready_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef IOMEM_STATS_EN
  // completed-transaction and timeout statistics
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      txcnt_q <= 16'h0;
      tocnt_q <= 8'h0;
    end else begin
      if (state_q == S_RESP) txcnt_q <= txcnt_q + 16'd1;
      if (to_hit && (tocnt_q != 8'hFF)) tocnt_q <= tocnt_q + 8'd1;
    end
  end
`endif

  // peripheral strobes are decoded from state so that the RNG strobe and the
  // capture of rng_do fall in the same cycle
  assign rng_go      = acc && (tgt_q == T_RNG) && !rng_wait;
  assign rng_we      = rng_go && wr;
  assign rng_re      = rng_go && !wr;
  assign rng_di      = (tgt_q == T_RNG) ? wdata_q : 32'h0;
  assign ram_we      = (acc && (tgt_q == T_RAM)) ? wstrb_q : 4'h0;
  assign ram_re      = acc && (tgt_q == T_RAM) && !wr;
  assign ram_addr    = (tgt_q == T_RAM) ? raddr_q : '0;
  assign ram_di      = (tgt_q == T_RAM) ? wdata_q : 32'h0;

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_o      = gpio_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_iomem_ctrl.sv
// Directed bench for iomem_ctrl: table of single transactions plus
// hand-written sequences for RNG wait/timeout, abort and mid-flight reset.
module tb_iomem_ctrl;

  localparam int RLAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [31:0] gpio_o;
  logic        rng_we, rng_re;
  logic [31:0] rng_di;
  logic [31:0] rng_do;
  logic        rng_wait;
  logic [3:0]  ram_we;
  logic        ram_re;
  logic [7:0]  ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_do;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  iomem_ctrl #(
    .RAM_ADDR_BIT(8), .RAM_LAT(RLAT), .RNG_TIMEOUT(64), .UNMAPPED_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .gpio_o(gpio_o),
    .rng_we(rng_we), .rng_re(rng_re), .rng_di(rng_di), .rng_do(rng_do), .rng_wait(rng_wait),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // RAM model: data for a strobe in cycle A is on ram_do during cycle A+RLAT
  logic [31:0] mem  [0:63];
  logic [31:0] pipe [0:RLAT-1];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_di[8*b +: 8];
    if (ram_re) pipe[0] <= mem[ram_addr[7:2]];
    for (int i = 1; i < RLAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_do = pipe[RLAT-1];

  // strobe monitor (free-running counts, sampled before/after each transaction)
  int n_rwe = 0, n_rre = 0, n_mwe = 0, n_mre = 0, n_bad = 0;
  logic [7:0] last_maddr = 8'h0;
  logic [3:0] last_mwe   = 4'h0;
  always @(posedge clk) begin
    if (rng_we) n_rwe <= n_rwe + 1;
    if (rng_re) n_rre <= n_rre + 1;
    if (ram_re) n_mre <= n_mre + 1;
    if (ram_we != 4'h0) begin
      n_mwe      <= n_mwe + 1;
      last_maddr <= ram_addr;
      last_mwe   <= ram_we;
    end
    if ((rng_we || rng_re) && rng_wait) n_bad <= n_bad + 1;
  end

  function automatic logic [15:0] snap();
    return {4'(n_rwe), 4'(n_rre), 4'(n_mwe), 4'(n_mre)};
  endfunction

  function automatic logic [15:0] sdiff(logic [15:0] a, logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = a[4*i +: 4] - b[4*i +: 4];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one bus transaction; drop_wait >= 0 lowers rng_wait at that negedge count
  task automatic xact(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      input int drop_wait, output logic [31:0] rd, output int lat);
    bit done;
    iomem_addr  = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    iomem_valid = 1'b1;
    lat  = 0;
    rd   = 32'h0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      lat++;
      if (iomem_ready) begin
        rd   = iomem_rdata;
        done = 1'b1;
      end else begin
        if (drop_wait >= 0 && lat == drop_wait) rng_wait = 1'b0;
        if (lat >= 300) begin
          checks++;
          errors++;
          $display("FAIL xact_ready_timeout: addr %h got no ready within %0d cycles", a, lat);
          done = 1'b1;
        end
      end
    end
    iomem_valid = 1'b0;
    @(negedge clk);
    chk("ready_single_cycle", {31'h0, iomem_ready}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] gpio;
    logic [15:0] str;   // {rng_we, rng_re, ram_we, ram_re} pulse counts
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV];

  logic [31:0] rd;
  int          lat;
  logic [15:0] s0;
  int          rdy_seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //               addr          wstrb  wdata          rdata         lat gpio          strobes
    tv[0]  = '{32'h0300_0000, 4'b0001, 32'h0000_00A5, 32'h0000_0000, 2, 32'h0000_00A5, 16'h0000};
    tv[1]  = '{32'h0300_0000, 4'b0000, 32'h0000_0000, 32'h0000_00A5, 2, 32'h0000_00A5, 16'h0000};
    tv[2]  = '{32'h0300_0000, 4'b1110, 32'h1234_5600, 32'h0000_00A5, 2, 32'h1234_56A5, 16'h0000};
    tv[3]  = '{32'h0300_0000, 4'b0000, 32'h0000_0000, 32'h1234_56A5, 2, 32'h1234_56A5, 16'h0000};
    tv[4]  = '{32'h0300_4000, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF, 2, 32'h1234_56A5, 16'h0000};
    tv[5]  = '{32'h0300_3000, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF, 2, 32'h1234_56A5, 16'h0000};
    tv[6]  = '{32'h0300_2100, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF, 2, 32'h1234_56A5, 16'h0000};
    tv[7]  = '{32'h0300_2010, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000, 2, 32'h1234_56A5, 16'h0010};
    tv[8]  = '{32'h0300_2010, 4'b0000, 32'h0000_0000, 32'hCAFE_F00D, RLAT+2, 32'h1234_56A5, 16'h0001};
    tv[9]  = '{32'h0300_2010, 4'b0100, 32'h00AB_0000, 32'h0000_0000, 2, 32'h1234_56A5, 16'h0010};
    tv[10] = '{32'h0300_2010, 4'b0000, 32'h0000_0000, 32'hCAAB_F00D, RLAT+2, 32'h1234_56A5, 16'h0001};
    tv[11] = '{32'h0300_20FC, 4'b1111, 32'h5A5A_5A5A, 32'h0000_0000, 2, 32'h1234_56A5, 16'h0010};
    tv[12] = '{32'h0300_20FC, 4'b0000, 32'h0000_0000, 32'h5A5A_5A5A, RLAT+2, 32'h1234_56A5, 16'h0001};
    tv[13] = '{32'h0300_1000, 4'b0000, 32'h0000_0000, 32'h1234_5678, 2, 32'h1234_56A5, 16'h0100};
    tv[14] = '{32'h0300_1000, 4'b1111, 32'h0000_0077, 32'h0000_0000, 2, 32'h1234_56A5, 16'h1000};

    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    rng_do      = 32'h1234_5678;
    rng_wait    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'h0, iomem_ready}, 32'h0);
    chk("reset_rdata", iomem_rdata, 32'h0);
    chk("reset_gpio", gpio_o, 32'h0);
    chk("reset_strobes", {22'h0, rng_we, rng_re, ram_we, ram_re, timeout_o, 2'b00},
        32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // table-driven single transactions
    for (int i = 0; i < NV; i++) begin
      s0 = snap();
      xact(tv[i].addr, tv[i].wstrb, tv[i].wdata, -1, rd, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].rdata);
      chk($sformatf("vec%0d_latency", i), lat, tv[i].lat);
      chk($sformatf("vec%0d_gpio", i), gpio_o, tv[i].gpio);
      chk($sformatf("vec%0d_strobes", i), {16'h0, sdiff(snap(), s0)}, {16'h0, tv[i].str});
    end

    // RAM write strobe contents
    xact(32'h0300_2010, 4'b1111, 32'hCAFE_F00D, -1, rd, lat);
    chk("ram_wr_we", {28'h0, last_mwe}, 32'hF);
    chk("ram_wr_addr", {24'h0, last_maddr}, 32'h10);

    // RNG read with rng_wait high for 5 cycles
    rng_wait = 1'b1;
    s0 = snap();
    xact(32'h0300_1000, 4'b0000, 32'h0, 5, rd, lat);
    chk("rngwait_rdata", rd, 32'h1234_5678);
    chk("rngwait_latency", lat, 7);
    chk("rngwait_strobes", {16'h0, sdiff(snap(), s0)}, 32'h0100);
    chk("rngwait_timeout", {31'h0, timeout_o}, 32'h0);
    chk("rng_strobe_during_wait", n_bad, 0);

    // RNG timeout: 64 cycles in RNG_WAIT after the ACCESS cycle
    rng_wait = 1'b1;
    s0 = snap();
    xact(32'h0300_1000, 4'b0000, 32'h0, -1, rd, lat);
    rng_wait = 1'b0;
    chk("timeout_rdata", rd, 32'hFFFF_FFFF);
    chk("timeout_latency", lat, 66);
    chk("timeout_strobes", {16'h0, sdiff(snap(), s0)}, 32'h0);
    chk("timeout_flag_set", {31'h0, timeout_o}, 32'h1);
    // bit 31 written without byte 3 enabled must not clear the flag
    xact(32'h0300_0000, 4'b0111, 32'h8000_0000, -1, rd, lat);
    chk("timeout_noclr_rdata", rd, 32'h1234_56A5);
    chk("timeout_noclr_gpio", gpio_o, 32'h1200_0000);
    chk("timeout_flag_kept", {31'h0, timeout_o}, 32'h1);
    xact(32'h0300_0000, 4'b1000, 32'h8000_0000, -1, rd, lat);
    chk("timeout_clr_rdata", rd, 32'h1200_0000);
    chk("timeout_clr_gpio", gpio_o, 32'h8000_0000);
    chk("timeout_flag_clr", {31'h0, timeout_o}, 32'h0);

    // abort: valid withdrawn during a RAM read; strobe completes, no ready
    s0 = snap();
    iomem_addr  = 32'h0300_2010;
    iomem_wstrb = 4'b0000;
    iomem_valid = 1'b1;
    @(negedge clk);
    iomem_valid = 1'b0;
    rdy_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (iomem_ready) rdy_seen++;
    end
    chk("abort_no_ready", rdy_seen, 0);
    chk("abort_strobes", {16'h0, sdiff(snap(), s0)}, 32'h0001);
    chk("abort_rdata_held", iomem_rdata, 32'h1200_0000);
    xact(32'h0300_0000, 4'b0000, 32'h0, -1, rd, lat);
    chk("post_abort_rdata", rd, 32'h8000_0000);
    chk("post_abort_latency", lat, 2);

    // asynchronous reset while waiting on the RNG
    rng_wait = 1'b1;
    iomem_addr  = 32'h0300_1000;
    iomem_wstrb = 4'b0000;
    iomem_valid = 1'b1;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_ready", {31'h0, iomem_ready}, 32'h0);
    chk("rst_mid_rdata", iomem_rdata, 32'h0);
    chk("rst_mid_gpio", gpio_o, 32'h0);
    chk("rst_mid_strobes", {22'h0, rng_we, rng_re, ram_we, ram_re, timeout_o, 2'b00},
        32'h0);
    iomem_valid = 1'b0;
    rng_wait    = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    xact(32'h0300_0000, 4'b0000, 32'h0, -1, rd, lat);
    chk("post_reset_rdata", rd, 32'h0);
    chk("post_reset_latency", lat, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
